// File: rtl/banco_registros_2r1w_pkg.sv
// Shared types and constants for the two-read/one-write register bank.
package banco_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned A_DEFAULT = 4;
  localparam int unsigned MAX_W     = 64;

  // Depth of the bank for a given address width.
  function automatic int unsigned depth(input int unsigned a);
    return 32'd1 << a;
  endfunction

  localparam int unsigned N = depth(A_DEFAULT);

  localparam logic [MAX_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/banco_registros_2r1w_contador_borrado.sv
// Post-reset clear sequencer: state register plus the sweep address counter.
module contador_borrado
  import banco_pkg::*;
#(
  parameter int unsigned A = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic [A-1:0] cnt,
  output logic         busy
);

  localparam int unsigned N_LOC = depth(A);
  localparam logic [A-1:0] LAST_ADDR = A'(N_LOC - 1);

  state_t       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;

  // Next state: sweep every address once, then settle in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = A'(cnt_q + A'(1));
      if (cnt_q == LAST_ADDR) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (state_q == CLEAR);

endmodule

// File: rtl/banco_registros_2r1w.sv
// Register bank with one write port, two registered read ports, write-first
// bypass and a self-clearing sweep of the storage array after reset.
module banco_registros_2r1w
  import banco_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned A       = 4,
  parameter int unsigned R0_ZERO = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [A-1:0] rd_addr1,
  input  logic [A-1:0] rd_addr2,
  output logic [W-1:0] data_out1,
  output logic [W-1:0] data_out2,
  output logic         busy,
  output logic         wr_err
);

  localparam int unsigned N_LOC  = depth(A);
  localparam bit          R0_EN  = (R0_ZERO != 0);
  localparam logic [W-1:0] ZERO_W = W'(ZERO_WORD);
  localparam logic [A-1:0] ADDR0  = '0;

  logic [W-1:0] mem_q [N_LOC];

  logic [A-1:0] cnt;
  logic         busy_int;

  logic         mem_we_d;
  logic [A-1:0] mem_waddr_d;
  logic [W-1:0] mem_wdata_d;

  logic [W-1:0] data_out1_q, data_out1_d;
  logic [W-1:0] data_out2_q, data_out2_d;
  logic         wr_err_q, wr_err_d;

  contador_borrado #(
    .A (A)
  ) u_contador_borrado (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .busy  (busy_int)
  );

  // Read resolution: sweep, hardwired zero, write-first bypass, then array.
  function automatic logic [W-1:0] resolve_read(
    input logic         in_busy,
    input logic [A-1:0] ra,
    input logic         we,
    input logic [A-1:0] wa,
    input logic [W-1:0] wd,
    input logic [W-1:0] arr_val
  );
    logic [W-1:0] res;
    if (in_busy) begin
      res = ZERO_W;
    end else if (R0_EN && (ra == ADDR0)) begin
      res = ZERO_W;
    end else if (we && (wa == ra)) begin
      res = wd;
    end else begin
      res = arr_val;
    end
    return res;
  endfunction

  // Array write port: zero-fill during the sweep, user writes once idle.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = wr_addr;
    mem_wdata_d = wr_data;
    if (!reset) begin
      if (busy_int) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = cnt;
        mem_wdata_d = ZERO_W;
      end else if (wr_en && !(R0_EN && (wr_addr == ADDR0))) begin
        mem_we_d = 1'b1;
      end
    end
  end

  always_comb begin
    data_out1_d = resolve_read(busy_int, rd_addr1, wr_en, wr_addr, wr_data, mem_q[rd_addr1]);
    data_out2_d = resolve_read(busy_int, rd_addr2, wr_en, wr_addr, wr_data, mem_q[rd_addr2]);
    wr_err_d    = wr_en && busy_int;
  end

  // Storage has no reset; the sweep provides the initial contents.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out1_q <= ZERO_W;
      data_out2_q <= ZERO_W;
      wr_err_q    <= 1'b0;
    end else begin
      data_out1_q <= data_out1_d;
      data_out2_q <= data_out2_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign data_out1 = data_out1_q;
  assign data_out2 = data_out2_q;
  assign wr_err    = wr_err_q;
  assign busy      = busy_int;

endmodule

// File: tb/tb_banco_registros_2r1w.sv
// Directed and random bench for banco_registros_2r1w, with and without R0_ZERO.
module tb_banco_registros_2r1w;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr1;
  logic [3:0] rd_addr2;

  logic [7:0] a_d1, a_d2, b_d1, b_d2;
  logic       a_busy, a_err, b_busy, b_err;

  always #5 clk = ~clk;

  banco_registros_2r1w #(.W(8), .A(4), .R0_ZERO(0)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out1(a_d1), .data_out2(a_d2), .busy(a_busy), .wr_err(a_err)
  );

  banco_registros_2r1w #(.W(8), .A(4), .R0_ZERO(1)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .data_out1(b_d1), .data_out2(b_d2), .busy(b_busy), .wr_err(b_err)
  );

  typedef struct {
    logic [7:0] a1, a2, b1, b2;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t q[$];

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  bit         m_clear = 1'b1;
  logic [3:0] m_cnt   = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [3:0] ra, input bit r0z);
    if (reset || m_clear) return 8'h00;
    if (r0z && ra == 4'd0) return 8'h00;
    if (wr_en && wr_addr == ra) return wr_data;
    return r0z ? mem_b[ra] : mem_a[ra];
  endfunction

  // One clock: predict, advance the model, then compare after the edge.
  task automatic step();
    exp_t e;
    e.a1  = model_rd(rd_addr1, 1'b0);
    e.a2  = model_rd(rd_addr2, 1'b0);
    e.b1  = model_rd(rd_addr1, 1'b1);
    e.b2  = model_rd(rd_addr2, 1'b1);
    e.err = !reset && m_clear && wr_en;
    if (reset) begin
      m_clear = 1'b1;
      m_cnt   = '0;
    end else if (m_clear) begin
      mem_a[m_cnt] = 8'h00;
      mem_b[m_cnt] = 8'h00;
      if (m_cnt == 4'd15) m_clear = 1'b0;
      m_cnt = m_cnt + 4'd1;
    end else if (wr_en) begin
      mem_a[wr_addr] = wr_data;
      if (wr_addr != 4'd0) mem_b[wr_addr] = wr_data;
    end
    e.busy = m_clear;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("a_data_out1", a_d1, e.a1);
    chk("a_data_out2", a_d2, e.a2);
    chk("b_data_out1", b_d1, e.b1);
    chk("b_data_out2", b_d2, e.b2);
    chk("a_busy", 8'(a_busy), 8'(e.busy));
    chk("b_busy", 8'(b_busy), 8'(e.busy));
    chk("a_wr_err", 8'(a_err), 8'(e.err));
    chk("b_wr_err", 8'(b_err), 8'(e.err));
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic [3:0] r1, input logic [3:0] r2);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr1 = r1; rd_addr2 = r2;
  endtask

  // Steps with reset low until busy drops; returns busy-high cycles seen.
  task automatic run_sweep(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!a_busy) break;
      busy_cycles++;
      drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i));
      step();
    end
  endtask

  initial begin
    int bc;
    reset = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'hxx;
      mem_b[i] = 8'hxx;
    end
    @(posedge clk);
    #1;

    // Single-cycle reset pulse, then the sweep with a rejected write inside it.
    step();
    reset = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 4'd5, 4'd9);
    step(); step(); step();
    drive(1'b1, 4'd2, 8'hFF, 4'd2, 4'd2);
    step();
    chk("err_pulse", 8'(a_err), 8'd1);
    bc = 5;
    drive(1'b0, 4'd0, 8'h00, 4'd2, 4'd3);
    step();
    chk("err_one_cycle", 8'(a_err), 8'd0);
    bc++;
    begin
      int rest;
      run_sweep(rest);
      bc = bc - 1 + rest;
    end
    chk("busy_len", 8'(bc), 8'd16);
    chk("busy_low", 8'(a_busy), 8'd0);

    // All entries read zero after the sweep.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i));
      step();
      chk("post_sweep_zero", a_d1, 8'h00);
    end

    // Write-first bypass.
    drive(1'b1, 4'd3, 8'hA5, 4'd3, 4'd4);
    step();
    chk("bypass_p1", a_d1, 8'hA5);
    chk("bypass_p2", a_d2, 8'h00);

    // Dual read of the same address.
    drive(1'b1, 4'd7, 8'h3C, 4'd0, 4'd1);
    step();
    drive(1'b0, 4'd0, 8'h00, 4'd7, 4'd7);
    step();
    chk("dual_p1", a_d1, 8'h3C);
    chk("dual_p2", a_d2, 8'h3C);

    // Address 0 handling with and without R0_ZERO.
    drive(1'b1, 4'd0, 8'h55, 4'd0, 4'd2);
    step();
    chk("r0_bypass_b", b_d1, 8'h00);
    chk("r0_no_err", 8'(b_err), 8'd0);
    drive(1'b1, 4'd1, 8'h55, 4'd0, 4'd0);
    step();
    chk("r0_array_b", b_d1, 8'h00);
    chk("r0_array_a", a_d1, 8'h55);
    drive(1'b0, 4'd0, 8'h00, 4'd1, 4'd3);
    step();
    chk("r1_readback", b_d1, 8'h55);

    // Reset mid-sweep restarts the clear sequence.
    drive(1'b1, 4'd5, 8'h77, 4'd0, 4'd0);
    step();
    drive(1'b1, 4'd9, 8'h99, 4'd5, 4'd0);
    step();
    reset = 1'b1;
    drive(1'b1, 4'd6, 8'h66, 4'd9, 4'd5);
    step();
    reset = 1'b0;
    drive(1'b0, 4'd0, 8'h00, 4'd0, 4'd0);
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_sweep(bc);
    chk("restart_busy_len", 8'(bc), 8'd16);
    drive(1'b0, 4'd0, 8'h00, 4'd5, 4'd9);
    step();
    chk("cleared_5", a_d1, 8'h00);
    chk("cleared_9", a_d2, 8'h00);
    drive(1'b0, 4'd0, 8'h00, 4'd6, 4'd6);
    step();
    chk("reset_write_dropped", a_d1, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
